// File: rtl/data_bus_control.sv
`default_nettype none
// ============================================================================
// Module   : data_bus_control
// Brief    : Byte-addressable RAM + GPIO/FAULT register bus with 2-cycle reads
// Revision : 1.0
// ============================================================================
module data_bus_control #(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    output logic        ready,
    output logic        busy,
    input  logic        wd,
    input  logic        rd,
    input  logic [1:0]  size_in,
    input  logic [1:0]  size_out,
    input  logic [31:0] addr_in,
    input  logic [31:0] addr_out,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    inout  wire         ext_data
);

    localparam int          c_IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] c_RAM_LIMIT  = 33'(DEPTH_WORDS) << 2;
    localparam logic [31:0] c_ADDR_GDATA = 32'h8000_0000;
    localparam logic [31:0] c_ADDR_GDIR  = 32'h8000_0004;
    localparam logic [31:0] c_ADDR_FAULT = 32'h8000_0008;
    localparam logic [1:0]  c_SZ_BYTE    = 2'b00;
    localparam logic [1:0]  c_SZ_HALF    = 2'b01;

    localparam logic [1:0]  c_S_IDLE = 2'd0;
    localparam logic [1:0]  c_S_WAIT = 2'd1;
    localparam logic [1:0]  c_S_DONE = 2'd2;

    typedef struct packed {
        logic ram;
        logic gdata;
        logic gdir;
        logic fault;
        logic unmapped;
        logic misaligned;
    } dec_t;

    function automatic dec_t decode_addr(input logic [31:0] a, input logic [1:0] sz);
        dec_t d;
        d.ram        = ({1'b0, a} < c_RAM_LIMIT);
        d.gdata      = (a == c_ADDR_GDATA);
        d.gdir       = (a == c_ADDR_GDIR);
        d.fault      = (a == c_ADDR_FAULT);
        d.unmapped   = !(d.ram || d.gdata || d.gdir || d.fault);
        d.misaligned = !d.unmapped &&
                       (((sz == c_SZ_HALF) && a[0]) || (sz[1] && (a[1:0] != 2'b00)));
        return d;
    endfunction

    logic [31:0]        r_mem [DEPTH_WORDS] = '{default: 32'h0};
    logic               r_ready;
    logic [1:0]         r_state;
    logic [31:0]        r_req_addr;
    logic [1:0]         r_req_size;
    logic [31:0]        r_data_out;
    logic               r_gpio_data;
    logic               r_gpio_dir;
    logic               r_gpio_pin;
    logic [1:0]         r_fault;

    dec_t               w_wr_dec;
    dec_t               w_rd_dec;
    logic               w_wr_en;
    logic               w_wr_misal;
    logic               w_wr_commit;
    logic               w_wr_ram;
    logic [c_IDX_W-1:0] w_wr_idx;
    logic [c_IDX_W-1:0] w_rd_idx;
    logic [3:0]         w_strb;
    logic [31:0]        w_wdata;
    logic [31:0]        w_rd_word;
    logic [31:0]        w_rd_shift;
    logic [31:0]        w_rd_data;
    logic               w_same_req;
    logic               w_rd_start;
    logic               w_busy;
    logic [1:0]         w_fault_set;
    logic [1:0]         w_fault_clr;

    // ------------------------------------------------------------------
    // Write path
    // ------------------------------------------------------------------
    assign w_wr_dec    = decode_addr(addr_in, size_in);
    assign w_wr_en     = wd && r_ready;
    // Registers accept word writes only; narrower ones are faulted like misalignment.
    assign w_wr_misal  = w_wr_en && !w_wr_dec.unmapped &&
                         (w_wr_dec.misaligned || (!w_wr_dec.ram && !size_in[1]));
    assign w_wr_commit = w_wr_en && !w_wr_dec.unmapped && !w_wr_misal;
    assign w_wr_ram    = w_wr_commit && w_wr_dec.ram;
    assign w_wr_idx    = addr_in[c_IDX_W+1:2];

    always_comb begin
        w_strb  = 4'b1111;
        w_wdata = data_in;
        case (size_in)
            c_SZ_BYTE: begin
                w_strb  = 4'b0001 << addr_in[1:0];
                w_wdata = {4{data_in[7:0]}};
            end
            c_SZ_HALF: begin
                w_strb  = addr_in[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{data_in[15:0]}};
            end
            default: begin
                w_strb  = 4'b1111;
                w_wdata = data_in;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_wr_ram) begin
            for (int b = 0; b < 4; b++) begin
                if (w_strb[b]) begin
                    r_mem[w_wr_idx][8*b +: 8] <= w_wdata[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read path: data is sampled on the WAIT->DONE edge from the latched request
    // ------------------------------------------------------------------
    assign w_rd_dec   = decode_addr(r_req_addr, r_req_size);
    assign w_rd_idx   = r_req_addr[c_IDX_W+1:2];

    always_comb begin
        w_rd_word = 32'h0;
        if (w_rd_dec.ram) begin
            w_rd_word = r_mem[w_rd_idx];
        end else if (w_rd_dec.gdata) begin
            w_rd_word = {31'h0, r_gpio_pin};
        end else if (w_rd_dec.gdir) begin
            w_rd_word = {31'h0, r_gpio_dir};
        end else if (w_rd_dec.fault) begin
            w_rd_word = {30'h0, r_fault};
        end
    end

    assign w_rd_shift = w_rd_word >> {r_req_addr[1:0], 3'b000};

    always_comb begin
        w_rd_data = 32'h0;
        if (!w_rd_dec.unmapped && !w_rd_dec.misaligned) begin
            case (r_req_size)
                c_SZ_BYTE: w_rd_data = {24'h0, w_rd_shift[7:0]};
                c_SZ_HALF: w_rd_data = {16'h0, r_req_addr[1] ? w_rd_word[31:16] : w_rd_word[15:0]};
                default:   w_rd_data = w_rd_word;
            endcase
        end
    end

    assign w_same_req = (addr_out == r_req_addr) && (size_out == r_req_size);
    assign w_rd_start = rd && r_ready;

    always_comb begin
        w_busy = 1'b0;
        case (r_state)
            c_S_IDLE: w_busy = w_rd_start;
            c_S_WAIT: w_busy = 1'b1;
            c_S_DONE: w_busy = w_rd_start && !w_same_req;
            default:  w_busy = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ready    <= 1'b0;
            r_state    <= c_S_IDLE;
            r_req_addr <= 32'h0;
            r_req_size <= 2'b00;
            r_data_out <= 32'h0;
        end else begin
            r_ready <= 1'b1;
            case (r_state)
                c_S_IDLE: begin
                    if (w_rd_start) begin
                        r_req_addr <= addr_out;
                        r_req_size <= size_out;
                        r_state    <= c_S_WAIT;
                    end
                end
                c_S_WAIT: begin
                    r_data_out <= w_rd_data;
                    r_state    <= c_S_DONE;
                end
                c_S_DONE: begin
                    if (!(w_rd_start && w_same_req)) begin
                        r_state <= c_S_IDLE;
                    end
                end
                default: r_state <= c_S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // GPIO and FAULT registers
    // ------------------------------------------------------------------
    assign w_fault_set[0] = w_wr_misal || ((r_state == c_S_WAIT) && w_rd_dec.misaligned);
    assign w_fault_set[1] = (w_wr_en && w_wr_dec.unmapped) ||
                            ((r_state == c_S_WAIT) && w_rd_dec.unmapped);
    assign w_fault_clr    = (w_wr_commit && w_wr_dec.fault) ? data_in[1:0] : 2'b00;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_gpio_data <= 1'b0;
            r_gpio_dir  <= 1'b0;
            r_gpio_pin  <= 1'b0;
            r_fault     <= 2'b00;
        end else begin
            r_gpio_pin <= ext_data;
            r_fault    <= (r_fault & ~w_fault_clr) | w_fault_set;
            if (w_wr_commit && w_wr_dec.gdata) begin
                r_gpio_data <= data_in[0];
            end
            if (w_wr_commit && w_wr_dec.gdir) begin
                r_gpio_dir <= data_in[0];
            end
        end
    end

    assign ext_data = r_gpio_dir ? r_gpio_data : 1'bz;

    assign ready    = r_ready;
    assign busy     = w_busy;
    assign data_out = r_data_out;

endmodule
`default_nettype wire

// File: tb/tb_data_bus_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_bus_control
// Brief    : Directed self-checking bench for data_bus_control
// Revision : 1.0
// ============================================================================
module tb_data_bus_control;

    logic        clk;
    logic        rst;
    logic        ready;
    logic        busy;
    logic        wd;
    logic        rd;
    logic [1:0]  size_in;
    logic [1:0]  size_out;
    logic [31:0] addr_in;
    logic [31:0] addr_out;
    logic [31:0] data_in;
    logic [31:0] data_out;
    wire         ext_pin;
    logic        r_tb_en;
    logic        r_tb_val;

    int n_checks;
    int n_errors;

    assign ext_pin = r_tb_en ? r_tb_val : 1'bz;

    data_bus_control #(.DEPTH_WORDS(1024)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .ready    (ready),
        .busy     (busy),
        .wd       (wd),
        .rd       (rd),
        .size_in  (size_in),
        .size_out (size_out),
        .addr_in  (addr_in),
        .addr_out (addr_out),
        .data_in  (data_in),
        .data_out (data_out),
        .ext_data (ext_pin)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
        @(negedge clk);
        wd      = 1'b1;
        addr_in = a;
        size_in = sz;
        data_in = d;
        @(negedge clk);
        wd      = 1'b0;
    endtask

    task automatic bus_read(input string tag, input logic [31:0] a, input logic [1:0] sz,
                            input logic [31:0] exp);
        int n;
        @(negedge clk);
        rd       = 1'b1;
        addr_out = a;
        size_out = sz;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 10);
        check_eq({tag, "_lat"}, 32'(n), 32'd2);
        check_eq(tag, data_out, exp);
        rd = 1'b0;
    endtask

    initial begin
        int n;
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b0;
        wd       = 1'b0;
        rd       = 1'b0;
        size_in  = 2'b10;
        size_out = 2'b10;
        addr_in  = 32'h0;
        addr_out = 32'h0;
        data_in  = 32'h0;
        r_tb_en  = 1'b0;
        r_tb_val = 1'b0;

        repeat (3) @(negedge clk);
        check_eq("rst_ready", {31'h0, ready}, 32'h0);
        check_eq("rst_busy", {31'h0, busy}, 32'h0);
        check_eq("rst_data", data_out, 32'h0);

        // Release reset with a write pending: ready is still low at the first edge.
        rst     = 1'b1;
        wd      = 1'b1;
        addr_in = 32'h30;
        size_in = 2'b10;
        data_in = 32'h1111_1111;
        #1 check_eq("ready_pre_edge", {31'h0, ready}, 32'h0);
        @(posedge clk);
        #1 check_eq("ready_post_edge", {31'h0, ready}, 32'h1);
        @(negedge clk);
        wd = 1'b0;
        bus_read("ignored_wr", 32'h30, 2'b10, 32'h0);

        bus_write(32'h10, 2'b10, 32'hDEAD_BEEF);
        bus_read("word_rd", 32'h10, 2'b10, 32'hDEAD_BEEF);

        bus_write(32'h11, 2'b00, 32'h0000_0055);
        bus_read("byte_rd11", 32'h11, 2'b00, 32'h0000_0055);
        bus_read("word_rd10", 32'h10, 2'b10, 32'hDEAD_55EF);
        bus_read("half_rd12", 32'h12, 2'b01, 32'h0000_DEAD);
        bus_read("half_rd10", 32'h10, 2'b01, 32'h0000_55EF);
        bus_read("byte_rd13", 32'h13, 2'b00, 32'h0000_00DE);

        bus_write(32'h13, 2'b10, 32'h1234_5678);
        bus_read("misal_noupd", 32'h10, 2'b10, 32'hDEAD_55EF);
        bus_read("fault_misal", 32'h8000_0008, 2'b10, 32'h1);
        bus_read("unmapped_rd", 32'h4000_0000, 2'b10, 32'h0);
        bus_read("fault_both", 32'h8000_0008, 2'b10, 32'h3);
        bus_write(32'h8000_0008, 2'b10, 32'h3);
        bus_read("fault_clr", 32'h8000_0008, 2'b10, 32'h0);

        // Same-cycle write and read of one address returns the new value.
        @(negedge clk);
        wd       = 1'b1;
        addr_in  = 32'h20;
        size_in  = 2'b10;
        data_in  = 32'hCAFE_F00D;
        rd       = 1'b1;
        addr_out = 32'h20;
        size_out = 2'b10;
        #1 check_eq("busy_comb", {31'h0, busy}, 32'h1);
        @(negedge clk);
        wd = 1'b0;
        n  = 1;
        while (busy && n < 10) begin
            @(negedge clk);
            n++;
        end
        check_eq("rw_same_lat", 32'(n), 32'd2);
        check_eq("rw_same", data_out, 32'hCAFE_F00D);
        @(negedge clk);
        check_eq("done_hold_busy", {31'h0, busy}, 32'h0);
        check_eq("done_hold_data", data_out, 32'hCAFE_F00D);
        rd = 1'b0;

        bus_write(32'h8000_0004, 2'b10, 32'h1);
        bus_write(32'h8000_0000, 2'b10, 32'h1);
        @(negedge clk);
        check_eq("gpio_drive", {31'h0, ext_pin}, 32'h1);
        bus_read("gpio_rd_out", 32'h8000_0000, 2'b10, 32'h1);
        bus_write(32'h8000_0004, 2'b10, 32'h0);
        r_tb_en  = 1'b1;
        r_tb_val = 1'b0;
        bus_read("gpio_rd_in0", 32'h8000_0000, 2'b10, 32'h0);
        r_tb_val = 1'b1;
        bus_read("gpio_rd_in1", 32'h8000_0000, 2'b10, 32'h1);
        r_tb_en  = 1'b0;

        // Leave non-reset state behind, then reset in the middle of a read.
        bus_write(32'h8000_0004, 2'b10, 32'h1);
        bus_write(32'h15, 2'b01, 32'hFFFF);
        bus_read("pre_rst_rd", 32'h10, 2'b10, 32'hDEAD_55EF);
        @(negedge clk);
        rd       = 1'b1;
        addr_out = 32'h10;
        size_out = 2'b10;
        @(negedge clk);
        check_eq("wait_busy", {31'h0, busy}, 32'h1);
        rst = 1'b0;
        #1;
        check_eq("abort_busy", {31'h0, busy}, 32'h0);
        check_eq("abort_ready", {31'h0, ready}, 32'h0);
        check_eq("abort_data", data_out, 32'h0);
        rd = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        bus_read("post_rst_ram", 32'h10, 2'b10, 32'hDEAD_55EF);
        bus_read("post_rst_fault", 32'h8000_0008, 2'b10, 32'h0);
        bus_read("post_rst_dir", 32'h8000_0004, 2'b10, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
